// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the three buses that meet at the data-memory arbiter:
//     cpu_*  : single-cycle CPU memory port and its clock-enable
//     dma_*  : DMA/debug request/grant/read-return channel
//     mem_*  : data memory port (combinational read, edge write)
//     stall_count : CPU cycles lost to DMA ownership
//   modport master : the environment (CPU, DMA, memory) side
//   modport slave  : the arbiter side
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // CPU side
  logic [ADDR_W-1:0] cpu_read_address;
  logic [ADDR_W-1:0] cpu_write_address;
  logic [DATA_W-1:0] cpu_write_data;
  logic              cpu_write_enable;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_clk_enable;
  // DMA side
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_r_address;
  logic [ADDR_W-1:0] mem_w_address;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_w_enable;
  logic [DATA_W-1:0] mem_o_data;
  // Status
  logic [15:0]       stall_count;

  modport master (
    output cpu_read_address, cpu_write_address, cpu_write_data, cpu_write_enable,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_o_data,
    input  cpu_read_data, cpu_clk_enable,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_r_address, mem_w_address, mem_w_data, mem_w_enable,
    input  stall_count
  );

  modport slave (
    input  cpu_read_address, cpu_write_address, cpu_write_data, cpu_write_enable,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_o_data,
    output cpu_read_data, cpu_clk_enable,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_r_address, mem_w_address, mem_w_data, mem_w_enable,
    output stall_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data memory between a single-cycle CPU and a DMA/debug
//   requester. The CPU owns the memory by default; a DMA request takes the
//   memory for a bounded burst of at most MAX_BURST transfers while the CPU
//   is frozen through cpu_clk_enable. Every edge spent in DMA ownership is
//   counted in a saturating 16-bit stall counter.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : dmem_arbiter_if.slave (cpu_*, dma_*, mem_*, stall_count)
//
//   Parameters:
//     ADDR_W, DATA_W : must match the widths of the connected interface
//     MAX_BURST      : transfers per ownership period, 1..255
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus
);

  localparam int              CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_burst_cnt, w_burst_nxt;
  logic              w_xfer;
  logic              w_dma_own;

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_stall;

  logic [ADDR_W-1:0] w_dma_addr;
  logic [DATA_W-1:0] w_dma_wdata;

  assign w_dma_addr  = bus.dma_addr;
  assign w_dma_wdata = bus.dma_wdata;
  assign w_dma_own   = (r_state == DMA_OWN);

  // -------------------------------------------------------------------------
  // Ownership FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CPU_OWN;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_xfer      = 1'b0;
    case (r_state)
      CPU_OWN: begin
        // Counter is held clear for the whole CPU period, so it is zero on
        // entry to DMA_OWN. Staying here for at least one cycle is what
        // gives the CPU its guaranteed slot between bursts.
        w_burst_nxt = '0;
        if (bus.dma_req) w_state_nxt = DMA_OWN;
      end
      DMA_OWN: begin
        w_xfer = bus.dma_req;
        if (w_xfer) w_burst_nxt = r_burst_cnt + CNT_W'(1);
        // An idle DMA_OWN cycle (req low) hands the memory straight back.
        if (!bus.dma_req || (r_burst_cnt == LAST)) w_state_nxt = CPU_OWN;
      end
      default: begin
        w_state_nxt = CPU_OWN;
        w_burst_nxt = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // DMA read return: registered, one cycle after the transfer cycle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_xfer && !bus.dma_we;
      if (w_xfer && !bus.dma_we) r_rdata <= bus.mem_o_data;
    end
  end

  // -------------------------------------------------------------------------
  // Stall counter: one count per edge taken in DMA_OWN, saturating
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_stall <= '0;
    else if (w_dma_own && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
  end

  // -------------------------------------------------------------------------
  // Memory / CPU muxing
  // -------------------------------------------------------------------------
  assign bus.mem_r_address = w_dma_own ? w_dma_addr  : bus.cpu_read_address;
  assign bus.mem_w_address = w_dma_own ? w_dma_addr  : bus.cpu_write_address;
  assign bus.mem_w_data    = w_dma_own ? w_dma_wdata : bus.cpu_write_data;
  // CPU strobes are dropped while the DMA owns the memory; the write enable
  // is also gated by reset so nothing lands in memory during reset.
  assign bus.mem_w_enable  = rst_n &
                             (w_dma_own ? (bus.dma_req & bus.dma_we)
                                        : bus.cpu_write_enable);

  // The CPU is frozen during DMA ownership, so what it sees on the read
  // bus then is irrelevant; pass memory data through unconditionally.
  assign bus.cpu_read_data  = bus.mem_o_data;
  assign bus.cpu_clk_enable = !w_dma_own;

  assign bus.dma_gnt     = w_dma_own;
  assign bus.dma_rvalid  = r_rvalid;
  assign bus.dma_rdata   = r_rdata;
  assign bus.stall_count = r_stall;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, edge write
  logic [31:0] mem [0:255];
  assign bus.mem_o_data = mem[bus.mem_r_address];
  always @(posedge clk) if (bus.mem_w_enable) mem[bus.mem_w_address] <= bus.mem_w_data;

  // Bench-side view of memory contents, updated only from stimulus intent
  logic [31:0] ref_mem [0:255];
  // Scoreboard of expected DMA read data
  logic [31:0] sb [$];

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  // gnt per cycle starting with the CPU_OWN cycle in which req rises
  int exp_gnt [15] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0};

  // Read-return monitor: every rvalid pulse pops one expected value
  always @(negedge clk) begin
    if (bus.dma_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_rvalid: got rdata=%h, required no rvalid", bus.dma_rdata);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (bus.dma_rdata !== e) begin
          failures++;
          $display("FAIL sb_rdata: got %h, required %h", bus.dma_rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h30; bus.dma_wdata = 32'h0;
    bus.cpu_write_enable = 1'b1; bus.cpu_write_address = 8'h30;
    bus.cpu_write_data = 32'hFFFF0000; bus.cpu_read_address = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.cpu_clk_enable !== 1'b1) begin failures++; $display("FAIL reset_clk_en: got %b, required 1", bus.cpu_clk_enable); end
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.mem_w_enable !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b, required 0", bus.mem_w_enable); end
    checks++; if (bus.stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall: got %0d, required 0", bus.stall_count); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b, required 0", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h, required 0", bus.dma_rdata); end
    tick();
    bus.dma_req = 1'b0; bus.cpu_write_enable = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL post_reset_gnt: got %b, required 0", bus.dma_gnt); end
    tick();
  endtask

  task automatic test_cpu_path();
    bus.cpu_write_address = 8'h20; bus.cpu_write_data = 32'h12345678; bus.cpu_write_enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_w_enable !== 1'b1) begin failures++; $display("FAIL cpu_wen: got %b, required 1", bus.mem_w_enable); end
    checks++; if (bus.mem_w_address !== 8'h20) begin failures++; $display("FAIL cpu_waddr: got %h, required 20", bus.mem_w_address); end
    tick(); ref_mem[8'h20] = 32'h12345678;
    bus.cpu_write_address = 8'h30; bus.cpu_write_data = 32'hA5A5A5A5;
    tick(); ref_mem[8'h30] = 32'hA5A5A5A5;
    bus.cpu_write_enable = 1'b0; bus.cpu_read_address = 8'h20;
    @(negedge clk);
    checks++; if (bus.cpu_read_data !== 32'h12345678) begin failures++; $display("FAIL cpu_read_20: got %h, required 12345678", bus.cpu_read_data); end
    tick(); bus.cpu_read_address = 8'h30;
    @(negedge clk);
    checks++; if (bus.cpu_read_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL cpu_read_30: got %h, required a5a5a5a5", bus.cpu_read_data); end
    tick();
  endtask

  task automatic test_single_write();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h10; bus.dma_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL wr_pre_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.cpu_clk_enable !== 1'b1) begin failures++; $display("FAIL wr_pre_clk_en: got %b, required 1", bus.cpu_clk_enable); end
    tick();
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt: got %b, required 1", bus.dma_gnt); end
    checks++; if (bus.mem_w_address !== 8'h10) begin failures++; $display("FAIL wr_waddr: got %h, required 10", bus.mem_w_address); end
    checks++; if (bus.mem_w_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_wdata: got %h, required deadbeef", bus.mem_w_data); end
    checks++; if (bus.mem_w_enable !== 1'b1) begin failures++; $display("FAIL wr_wen: got %b, required 1", bus.mem_w_enable); end
    checks++; if (bus.cpu_clk_enable !== 1'b0) begin failures++; $display("FAIL wr_clk_en: got %b, required 0", bus.cpu_clk_enable); end
    tick(); ref_mem[8'h10] = 32'hDEADBEEF; exp_stall++;
    bus.dma_req = 1'b0;
    // burst not exhausted, so a req-low DMA_OWN cycle follows before release
    @(negedge clk);
    checks++; if (bus.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL wr_stall_1: got %0d, required %0d", bus.stall_count, exp_stall); end
    checks++; if (bus.dma_gnt !== 1'b1) begin failures++; $display("FAIL wr_idle_gnt: got %b, required 1", bus.dma_gnt); end
    checks++; if (bus.mem_w_enable !== 1'b0) begin failures++; $display("FAIL wr_idle_wen: got %b, required 0", bus.mem_w_enable); end
    tick(); exp_stall++;
    bus.cpu_read_address = 8'h10;
    @(negedge clk);
    checks++; if (bus.cpu_clk_enable !== 1'b1) begin failures++; $display("FAIL wr_post_clk_en: got %b, required 1", bus.cpu_clk_enable); end
    checks++; if (bus.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL wr_stall_2: got %0d, required %0d", bus.stall_count, exp_stall); end
    checks++; if (bus.cpu_read_data !== ref_mem[8'h10]) begin failures++; $display("FAIL wr_mem_10: got %h, required %h", bus.cpu_read_data, ref_mem[8'h10]); end
    tick();
  endtask

  task automatic test_read();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h20;
    sb.push_back(ref_mem[8'h20]);
    tick();
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt: got %b, required 1", bus.dma_gnt); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL rd_early_rvalid: got %b, required 0", bus.dma_rvalid); end
    tick(); exp_stall++;
    bus.dma_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.dma_rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid: got %b, required 1", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 32'h12345678) begin failures++; $display("FAIL rd_rdata: got %h, required 12345678", bus.dma_rdata); end
    tick(); exp_stall++;
    @(negedge clk);
    checks++; if (bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_pulse: got %b, required 0", bus.dma_rvalid); end
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL rd_post_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL rd_stall: got %0d, required %0d", bus.stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_burst_limit();
    int n;
    logic xfer;
    n = 0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h40; bus.dma_wdata = 32'hC0DE0000;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      xfer = (exp_gnt[i] == 1) && bus.dma_req;
      checks++;
      if (bus.dma_gnt !== 1'(exp_gnt[i])) begin failures++; $display("FAIL burst_gnt[%0d]: got %b, required %0d", i, bus.dma_gnt, exp_gnt[i]); end
      checks++;
      if (bus.mem_w_enable !== xfer) begin failures++; $display("FAIL burst_wen[%0d]: got %b, required %b", i, bus.mem_w_enable, xfer); end
      tick();
      if (xfer) begin
        ref_mem[bus.dma_addr] = bus.dma_wdata;
        n++;
        if (n == 10) bus.dma_req = 1'b0;
        else begin
          bus.dma_addr  = 8'(8'h40 + n);
          bus.dma_wdata = 32'hC0DE0000 | 32'(n);
        end
      end
    end
    exp_stall += 11;
    @(negedge clk);
    checks++; if (bus.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL burst_stall: got %0d, required %0d", bus.stall_count, exp_stall); end
    tick();
  endtask

  task automatic test_isolation();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40;
    sb.push_back(ref_mem[8'h40]);
    tick();
    bus.cpu_write_enable = 1'b1; bus.cpu_write_address = 8'h30; bus.cpu_write_data = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.dma_gnt !== 1'b1) begin failures++; $display("FAIL iso_gnt[%0d]: got %b, required 1", i, bus.dma_gnt); end
      checks++; if (bus.mem_w_enable !== 1'b0) begin failures++; $display("FAIL iso_wen[%0d]: got %b, required 0", i, bus.mem_w_enable); end
      tick();
      if (i < 3) begin
        bus.dma_addr = 8'(8'h41 + i);
        sb.push_back(ref_mem[8'(8'h41 + i)]);
      end
    end
    bus.cpu_write_enable = 1'b0; bus.dma_req = 1'b0;
    exp_stall += 4;
    @(negedge clk);
    checks++; if (bus.cpu_clk_enable !== 1'b1) begin failures++; $display("FAIL iso_release: got %b, required 1", bus.cpu_clk_enable); end
    checks++; if (bus.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL iso_stall: got %0d, required %0d", bus.stall_count, exp_stall); end
    tick();
    bus.cpu_read_address = 8'h30;
    @(negedge clk);
    checks++; if (bus.cpu_read_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL iso_mem_30: got %h, required a5a5a5a5", bus.cpu_read_data); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL iso_sb_drain: got %0d pending, required 0", sb.size()); end
    tick();
  endtask

  task automatic test_req_withdraw();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h20;
    #3 bus.dma_req = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL withdraw_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.cpu_clk_enable !== 1'b1) begin failures++; $display("FAIL withdraw_clk_en: got %b, required 1", bus.cpu_clk_enable); end
    tick();
  endtask

  task automatic test_reset_midburst();
    // no scoreboard entry: the pending read return is abandoned by reset
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h20;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL mid_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid: got %b, required 0", bus.dma_rvalid); end
    checks++; if (bus.cpu_clk_enable !== 1'b1) begin failures++; $display("FAIL mid_clk_en: got %b, required 1", bus.cpu_clk_enable); end
    tick();
    bus.dma_req = 1'b0; rst_n = 1'b1; exp_stall = 0;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin failures++; $display("FAIL mid_post_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.stall_count !== 16'd0) begin failures++; $display("FAIL mid_post_stall: got %0d, required 0", bus.stall_count); end
    tick();
    // re-request after reset: a fresh grant and a fresh stall count
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h41;
    sb.push_back(ref_mem[8'h41]);
    tick();
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1) begin failures++; $display("FAIL rereq_gnt: got %b, required 1", bus.dma_gnt); end
    tick(); exp_stall++;
    bus.dma_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.stall_count !== 16'(exp_stall)) begin failures++; $display("FAIL rereq_stall: got %0d, required %0d", bus.stall_count, exp_stall); end
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cpu_read_address = '0; bus.cpu_write_address = '0;
    bus.cpu_write_data = '0; bus.cpu_write_enable = 1'b0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    #2;
    test_reset();
    test_cpu_path();
    test_single_write();
    test_read();
    test_burst_limit();
    test_isolation();
    test_req_withdraw();
    test_reset_midburst();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL final_sb_drain: got %0d pending, required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
